// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes from the host and packs them
// little-endian into 32-bit words. Each completed word is written out with an
// auto-incrementing word address. A load ends when the line has been idle for a
// timeout after the last byte, or when the last address has been written.
module uart_prog_loader #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BAUD         = 115_200,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              word_we,
  output logic [ADDR_W-1:0] word_addr,
  output logic [31:0]       word_data,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {L_IDLE, L_LOAD} ld_state_t;

  rx_state_t         rx_state;
  ld_state_t         ld_state;
  logic              rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] addr;
  logic [TO_W-1:0]   tcnt;
  logic              armed;
  logic              ending;

  // Bring the asynchronous serial line into the clock domain; rx_prev gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte receiver: mid-bit sampling, held in R_IDLE whenever no load is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= R_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (!busy) begin
        rx_state <= R_IDLE;
        clk_cnt  <= '0;
        bit_idx  <= '0;
        if (start) frame_err <= 1'b0;
      end else begin
        case (rx_state)
          R_IDLE: begin
            if (rx_prev && !rx_sync) begin
              rx_state <= R_START;
              clk_cnt  <= '0;
            end
          end
          R_START: begin
            if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
              clk_cnt  <= '0;
              bit_idx  <= '0;
              rx_state <= rx_sync ? R_IDLE : R_DATA;
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
          R_DATA: begin
            if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
              clk_cnt   <= '0;
              shift_reg <= {rx_sync, shift_reg[7:1]};
              if (bit_idx == 3'd7) rx_state <= R_STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
          R_STOP: begin
            if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
              clk_cnt  <= '0;
              rx_state <= R_IDLE;
              if (rx_sync) begin
                byte_valid <= 1'b1;
                byte_data  <= shift_reg;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  // Loader: packs bytes into words, writes them out, and ends the load on timeout or full address space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state  <= L_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_we   <= 1'b0;
      word_addr <= '0;
      word_data <= '0;
      overflow  <= 1'b0;
      byte_idx  <= '0;
      word_buf  <= '0;
      addr      <= '0;
      tcnt      <= '0;
      armed     <= 1'b0;
      ending    <= 1'b0;
    end else begin
      word_we <= 1'b0;
      done    <= 1'b0;
      case (ld_state)
        L_IDLE: begin
          ending <= 1'b0;
          if (start) begin
            ld_state <= L_LOAD;
            busy     <= 1'b1;
            addr     <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            tcnt     <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        L_LOAD: begin
          if (ending) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            ending   <= 1'b0;
            ld_state <= L_IDLE;
          end else if (byte_valid) begin
            armed <= 1'b1;
            tcnt  <= '0;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                word_we   <= 1'b1;
                word_addr <= addr;
                word_data <= {byte_data, word_buf};
                word_buf  <= '0;
                addr      <= addr + ADDR_W'(1);
                if (addr == '1) begin
                  overflow <= 1'b1;
                  ending   <= 1'b1;
                end
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end else if (armed && rx_state == R_IDLE) begin
            if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
              ending <= 1'b1;
              if (byte_idx != 2'd0) begin
                word_we   <= 1'b1;
                word_addr <= addr;
                word_data <= {8'h00, word_buf};
                word_buf  <= '0;
                byte_idx  <= '0;
                addr      <= addr + ADDR_W'(1);
                if (addr == '1) overflow <= 1'b1;
              end
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table of directed loads, randomized loads checked
// against a byte-list model, and hand-written glitch and mid-load reset sequences.
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int CLK_HZ       = 10_000_000;
  localparam int BAUD         = 200_000;
  localparam int ADDR_W       = 2;
  localparam int TIMEOUT_BITS = 16;
  localparam int CPB          = CLK_HZ / BAUD;
  localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CPB;
  localparam int DEPTH        = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              uart_rx;
  logic              start;
  logic              busy;
  logic              done;
  logic              word_we;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       word_data;
  logic              frame_err;
  logic              overflow;

  uart_prog_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .start(start),
    .busy(busy), .done(done), .word_we(word_we), .word_addr(word_addr),
    .word_data(word_data), .frame_err(frame_err), .overflow(overflow)
  );

  typedef struct {
    int          nbytes;
    logic [159:0] bytes;
    logic [19:0] bad;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic        exp_fe;
    logic        exp_ovf;
  } vec_t;

  int                checks = 0;
  int                errors = 0;
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  int                done_cnt = 0;
  int                done_busy_bad = 0;
  int                we_idle_bad = 0;
  logic [7:0]        stim_bytes[$];
  bit                stim_bad[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic              exp_fe;
  logic              exp_ovf;
  vec_t              vecs[5];

  // 10 MHz clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Records every write strobe and done pulse, and flags strobes/dones seen with the wrong busy level.
  always @(negedge clk) begin
    if (rst_n) begin
      if (word_we) begin
        cap_addr.push_back(word_addr);
        cap_data.push_back(word_data);
        if (!busy) we_idle_bad++;
      end
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
    end
  end

  // Hard stop if something hangs.
  initial begin
    #9_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Reference: drop bad-stop bytes, chop the rest into little-endian words, stop at the last address.
  task automatic buildExpected();
    logic [7:0] good[$];
    int nw;
    exp_addr.delete();
    exp_data.delete();
    exp_fe = 1'b0;
    for (int i = 0; i < stim_bytes.size(); i++) begin
      if (stim_bad[i]) exp_fe = 1'b1;
      else good.push_back(stim_bytes[i]);
    end
    nw = 0;
    for (int i = 0; i < good.size() && nw < DEPTH; i += 4) begin
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++)
        if (i + k < good.size()) w[8*k +: 8] = good[i + k];
      exp_addr.push_back(ADDR_W'(nw));
      exp_data.push_back(w);
      nw++;
    end
    exp_ovf = (nw == DEPTH);
  endtask

  task automatic waitDone(input int base_d);
    int c;
    c = 0;
    while (done_cnt == base_d && c < TIMEOUT_CYC + 300) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic applyStimulus(output int base_w, output int base_d);
    base_w = cap_addr.size();
    base_d = done_cnt;
    pulseStart();
    for (int i = 0; i < stim_bytes.size(); i++) sendByte(stim_bytes[i], stim_bad[i]);
    waitDone(base_d);
  endtask

  task automatic checkLoad(input string tag, input int bw, input int bd);
    checkOutput({tag, "_nwords"}, cap_addr.size() - bw, exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (bw + i < cap_addr.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), cap_addr[bw + i], exp_addr[i]);
        checkOutput($sformatf("%s_data%0d", tag, i), cap_data[bw + i], exp_data[i]);
      end
    end
    checkOutput({tag, "_frame_err"}, frame_err, exp_fe);
    checkOutput({tag, "_overflow"}, overflow, exp_ovf);
    checkOutput({tag, "_done_count"}, done_cnt - bd, 1);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_busy_with_done"}, done_busy_bad, 0);
    checkOutput({tag, "_we_when_idle"}, we_idle_bad, 0);
  endtask

  initial begin
    int bw, bd;
    logic [159:0] seq20;
    string tag;

    // Directed loads: {nbytes, bytes (byte k at bits 8k), bad-stop mask, words, first, last, fe, ovf}
    seq20 = '0;
    for (int k = 0; k < 20; k++) seq20[8*k +: 8] = 8'(16 + k);
    vecs[0] = '{4,  160'h13,               20'h0, 1, 32'h00000013, 32'h00000013, 1'b0, 1'b0};
    vecs[1] = '{8,  160'h0807060504030201, 20'h0, 2, 32'h04030201, 32'h08070605, 1'b0, 1'b0};
    vecs[2] = '{3,  160'hCCBBAA,           20'h0, 1, 32'h00CCBBAA, 32'h00CCBBAA, 1'b0, 1'b0};
    vecs[3] = '{5,  160'h5544332211,       20'h2, 1, 32'h55443311, 32'h55443311, 1'b1, 1'b0};
    vecs[4] = '{20, seq20,                 20'h0, 4, 32'h13121110, 32'h1F1E1D1C, 1'b0, 1'b1};

    uart_rx = 1'b1;
    start   = 1'b0;
    rst_n   = 1'b1;
    #10 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_word_we", word_we, 0);
    checkOutput("reset_word_addr", word_addr, 0);
    checkOutput("reset_word_data", word_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      tag = $sformatf("vec%0d", r);
      stim_bytes.delete();
      stim_bad.delete();
      for (int k = 0; k < vecs[r].nbytes; k++) begin
        stim_bytes.push_back(vecs[r].bytes[8*k +: 8]);
        stim_bad.push_back(vecs[r].bad[k]);
      end
      buildExpected();
      applyStimulus(bw, bd);
      checkLoad(tag, bw, bd);
      checkOutput({tag, "_tbl_nwords"}, cap_addr.size() - bw, vecs[r].exp_words);
      checkOutput({tag, "_tbl_fe"}, frame_err, vecs[r].exp_fe);
      checkOutput({tag, "_tbl_ovf"}, overflow, vecs[r].exp_ovf);
      if (cap_data.size() > bw) begin
        checkOutput({tag, "_tbl_first"}, cap_data[bw], vecs[r].exp_first);
        checkOutput({tag, "_tbl_last"}, cap_data[cap_data.size() - 1], vecs[r].exp_last);
      end else begin
        checkOutput({tag, "_tbl_present"}, 0, 1);
      end
    end

    for (int r = 0; r < 5; r++) begin
      int n;
      tag = $sformatf("rand%0d", r);
      n = $urandom_range(1, 9);
      stim_bytes.delete();
      stim_bad.delete();
      for (int k = 0; k < n; k++) begin
        stim_bytes.push_back(8'($urandom));
        stim_bad.push_back(k > 0 && $urandom_range(0, 7) == 0);
      end
      buildExpected();
      applyStimulus(bw, bd);
      checkLoad(tag, bw, bd);
    end

    // Short low glitch: no byte, no frame error, timeout stays unarmed; start mid-load is ignored.
    bw = cap_addr.size();
    bd = done_cnt;
    pulseStart();
    @(negedge clk) uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (TIMEOUT_CYC + 300) @(negedge clk);
    checkOutput("glitch_busy", busy, 1);
    checkOutput("glitch_done", done_cnt - bd, 0);
    checkOutput("glitch_writes", cap_addr.size() - bw, 0);
    checkOutput("glitch_frame_err", frame_err, 0);
    sendByte(8'h5A, 1'b0);
    pulseStart();
    sendByte(8'h6B, 1'b0);
    waitDone(bd);
    checkOutput("glitch_nwords", cap_addr.size() - bw, 1);
    if (cap_addr.size() > bw) begin
      checkOutput("glitch_addr", cap_addr[bw], 0);
      checkOutput("glitch_data", cap_data[bw], 32'h00006B5A);
    end
    checkOutput("glitch_done_count", done_cnt - bd, 1);

    // Reset in the middle of a load aborts at once with no write and no done.
    bw = cap_addr.size();
    bd = done_cnt;
    pulseStart();
    sendByte(8'h77, 1'b1);
    sendByte(8'h42, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("prereset_busy", busy, 1);
    checkOutput("prereset_frame_err", frame_err, 1);
    #20 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_frame_err", frame_err, 0);
    checkOutput("abort_word_we", word_we, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_word_data", word_data, 0);
    checkOutput("abort_overflow", overflow, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (TIMEOUT_CYC + 300) @(negedge clk);
    checkOutput("abort_no_writes", cap_addr.size() - bw, 0);
    checkOutput("abort_no_done", done_cnt - bd, 0);
    checkOutput("abort_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
